fpu_issue_queue: RTL

//  Upstream feeder for the fpu core: accepts operand requests over valid/ready,

---
 rtl/fpu_issue_queue.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue
//   Feeds the fpu core. It accepts operand requests over valid/ready,
//   buffers them, and issues at most one per cycle onto the registered fpu
//   A/B/opcode inputs. It captures fpu O after the fixed core latency and
//   returns the results in order over a valid/ready response port.
//   A request is issued only while a result slot is reserved for it, so a
//   result is never dropped.
//
// Optional feature: define FPU_ISSUE_TAG_EN to add the req_tag and rsp_tag
//   ports. Each tag travels with its request and comes back with its result.
//
// Ports
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready  request handshake; req_ready = request FIFO not full
//   req_a, req_b, req_op operands and opcode (the opcode passes through as-is)
//   req_tag              request tag (FPU_ISSUE_TAG_EN only)
//   fpu_a, fpu_b, fpu_op registered drive to the fpu core
//   fpu_o                fpu core result
//   rsp_valid/rsp_ready  response handshake; rsp_data = oldest result
//   rsp_tag              tag of the oldest result (FPU_ISSUE_TAG_EN only)
//   busy                 work buffered, in flight or waiting to be returned
module fpu_issue_queue #(
   parameter int FPU_LATENCY = 2,
   parameter int REQ_DEPTH   = 4,
   parameter int RSP_DEPTH   = 4,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [1:0]       req_op,
`ifdef FPU_ISSUE_TAG_EN
   input  logic [TAG_W-1:0] req_tag,
`endif
   output logic [31:0]      fpu_a,
   output logic [31:0]      fpu_b,
   output logic [1:0]       fpu_op,
   input  logic [31:0]      fpu_o,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
`ifdef FPU_ISSUE_TAG_EN
   output logic [TAG_W-1:0] rsp_tag,
`endif
   output logic             busy
);

   localparam int RQ_AW = $clog2(REQ_DEPTH);
   localparam int RS_AW = $clog2(RSP_DEPTH);
   localparam int CR_W  = RS_AW + 1;
   localparam logic [RQ_AW:0] RQ_FULL   = REQ_DEPTH[RQ_AW:0];
   localparam logic [CR_W-1:0] CR_INIT  = RSP_DEPTH[CR_W-1:0];

   // request FIFO
   logic [31:0]      rq_a  [REQ_DEPTH];
   logic [31:0]      rq_b  [REQ_DEPTH];
   logic [1:0]       rq_op [REQ_DEPTH];
   logic [RQ_AW-1:0] rq_wp, rq_rp;
   logic [RQ_AW:0]   rq_cnt;

   // result FIFO
   logic [31:0]      rs_d  [RSP_DEPTH];
   logic [RS_AW-1:0] rs_wp, rs_rp;
   logic [RS_AW:0]   rs_cnt;

   logic [CR_W-1:0]        credits;
   logic [FPU_LATENCY-1:0] vld_p;
   logic                   push_rq, issue, capture, pop_rs;

   // req_ready depends only on registered state, never on rsp_ready
   assign req_ready = (rq_cnt != RQ_FULL);
   assign push_rq   = req_valid & req_ready;
   assign issue     = (rq_cnt != '0) && (credits != '0);
   assign capture   = vld_p[FPU_LATENCY-1];
   assign rsp_valid = (rs_cnt != '0);
   assign pop_rs    = rsp_valid & rsp_ready;
   assign rsp_data  = rs_d[rs_rp];
   assign busy      = (rq_cnt != '0) | (|vld_p) | (rs_cnt != '0);

   // ---- request FIFO control ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rq_wp  <= '0;
         rq_rp  <= '0;
         rq_cnt <= '0;
      end else begin
         if (push_rq) rq_wp <= rq_wp + 1'b1;
         if (issue)   rq_rp <= rq_rp + 1'b1;
         if (push_rq && !issue)      rq_cnt <= rq_cnt + 1'b1;
         else if (!push_rq && issue) rq_cnt <= rq_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_rq) begin
         rq_a[rq_wp]  <= req_a;
         rq_b[rq_wp]  <= req_b;
         rq_op[rq_wp] <= req_op;
      end
   end

   // ---- issue stage: fpu input registers, held when nothing issues ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpu_a  <= '0;
         fpu_b  <= '0;
         fpu_op <= '0;
      end else if (issue) begin
         fpu_a  <= rq_a[rq_rp];
         fpu_b  <= rq_b[rq_rp];
         fpu_op <= rq_op[rq_rp];
      end
   end

   // ---- in-flight valid pipe: the last bit marks fpu_o as valid ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= issue;
         for (int i = 1; i < FPU_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // Credits count result slots that are neither occupied nor reserved by
   // an in-flight operation. An issue and a pop in the same cycle cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits <= CR_INIT;
      end else if (issue && !pop_rs) begin
         credits <= credits - 1'b1;
      end else if (!issue && pop_rs) begin
         credits <= credits + 1'b1;
      end
   end

   // ---- result FIFO: never overflows because of the credit reservation ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_wp  <= '0;
         rs_rp  <= '0;
         rs_cnt <= '0;
      end else begin
         if (capture) rs_wp <= rs_wp + 1'b1;
         if (pop_rs)  rs_rp <= rs_rp + 1'b1;
         if (capture && !pop_rs)      rs_cnt <= rs_cnt + 1'b1;
         else if (!capture && pop_rs) rs_cnt <= rs_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) rs_d[rs_wp] <= fpu_o;
   end

`ifdef FPU_ISSUE_TAG_EN
   logic [TAG_W-1:0] rq_tag [REQ_DEPTH];
   logic [TAG_W-1:0] tag_p  [FPU_LATENCY];
   logic [TAG_W-1:0] rs_tag [RSP_DEPTH];

   always_ff @(posedge clk) begin
      if (push_rq) rq_tag[rq_wp] <= req_tag;
   end

   // The tag pipe shifts every cycle. A stage holds a real tag only where
   // the matching vld_p bit is set.
   always_ff @(posedge clk) begin
      tag_p[0] <= rq_tag[rq_rp];
      for (int i = 1; i < FPU_LATENCY; i++) tag_p[i] <= tag_p[i-1];
      if (capture) rs_tag[rs_wp] <= tag_p[FPU_LATENCY-1];
   end

   assign rsp_tag = rs_tag[rs_rp];
`endif

endmodule
